// File: rtl/sram_sel_encoder.sv
// Round-robin request-to-select encoder feeding the 4:16 SRAM word decoder.
// Requests collect in a pending vector and issue one at a time as {enable, sel}, with valid/ready backpressure.
module sram_sel_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        clr,
  input  logic        ready,
  output logic [3:0]  sel,
  output logic        enable,
  output logic [15:0] pending,
  output logic        overflow
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t      state;
  logic [3:0]  ptr;
  logic        found;
  logic [3:0]  idx;
  logic [3:0]  probe;
  logic        load;
  logic [15:0] load_mask;

  // First set bit of pending at or above ptr, wrapping 15 -> 0.
  always_comb begin
    found = 1'b0;
    idx   = 4'd0;
    probe = 4'd0;
    for (int i = 0; i < 16; i++) begin
      probe = ptr + 4'(i);
      if (!found && pending[probe]) begin
        found = 1'b1;
        idx   = probe;
      end
    end
  end

  always_comb begin
    load      = found && ((state == IDLE) || ready);
    load_mask = load ? (16'h0001 << idx) : 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= 4'd0;
      enable   <= 1'b0;
      pending  <= 16'h0000;
      overflow <= 1'b0;
      ptr      <= 4'd0;
    end else if (clr) begin
      state    <= IDLE;
      enable   <= 1'b0;
      pending  <= 16'h0000;
      overflow <= 1'b0;
    end else begin
      pending <= (pending & ~load_mask) | req;
      // A bit being loaded this edge may be re-requested without loss.
      if (|(req & pending & ~load_mask))
        overflow <= 1'b1;
      if (load) begin
        state  <= GRANT;
        sel    <= idx;
        enable <= 1'b1;
        ptr    <= idx + 4'd1;
      end else if (state == GRANT && ready) begin
        state  <= IDLE;
        enable <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_sel_encoder.sv
// Directed self-checking bench for sram_sel_encoder using immediate assertions.
module tb_sram_sel_encoder;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        clr;
  logic        ready;
  logic [3:0]  sel;
  logic        enable;
  logic [15:0] pending;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  sram_sel_encoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .clr      (clr),
    .ready    (ready),
    .sel      (sel),
    .enable   (enable),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_sel, input logic e_en,
                         input logic [15:0] e_pend, input logic e_ovf);
    chk({tag, ".sel"}, {28'd0, sel}, {28'd0, e_sel});
    chk({tag, ".enable"}, {31'd0, enable}, {31'd0, e_en});
    chk({tag, ".pending"}, {16'd0, pending}, {16'd0, e_pend});
    chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, e_ovf});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 16'h0000;
    clr   = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 16'hFFFF;
    clr   = 1'b0;
    ready = 1'b1;

    // reset with requests present
    tick();
    chk_out("rst1", 4'd0, 1'b0, 16'h0000, 1'b0);
    tick();
    chk_out("rst2", 4'd0, 1'b0, 16'h0000, 1'b0);
    rst_n = 1'b1;
    req   = 16'h0000;
    tick();
    tick();
    chk_out("rst_rel", 4'd0, 1'b0, 16'h0000, 1'b0);

    // single request
    req = 16'h0020;
    tick();
    chk_out("single_e1", 4'd0, 1'b0, 16'h0020, 1'b0);
    req = 16'h0000;
    tick();
    chk_out("single_e2", 4'd5, 1'b1, 16'h0000, 1'b0);
    tick();
    chk_out("single_e3", 4'd5, 1'b0, 16'h0000, 1'b0);

    // wrap and round-robin
    do_reset();
    ready = 1'b1;
    req   = 16'h8001;
    tick();
    chk_out("wrap_p", 4'd0, 1'b0, 16'h8001, 1'b0);
    req = 16'h0000;
    tick();
    chk_out("wrap_g0", 4'd0, 1'b1, 16'h8000, 1'b0);
    tick();
    chk_out("wrap_g15", 4'd15, 1'b1, 16'h0000, 1'b0);
    tick();
    chk_out("wrap_idle", 4'd15, 1'b0, 16'h0000, 1'b0);
    req = 16'h0003;
    tick();
    req = 16'h0000;
    tick();
    chk_out("rr_g0", 4'd0, 1'b1, 16'h0002, 1'b0);
    tick();
    chk_out("rr_g1", 4'd1, 1'b1, 16'h0000, 1'b0);
    tick();
    chk_out("rr_idle", 4'd1, 1'b0, 16'h0000, 1'b0);

    // backpressure
    do_reset();
    ready = 1'b0;
    req   = 16'h0006;
    tick();
    chk_out("bp_p", 4'd0, 1'b0, 16'h0006, 1'b0);
    req = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_out("bp_hold", 4'd1, 1'b1, 16'h0004, 1'b0);
    end
    ready = 1'b1;
    tick();
    chk_out("bp_g2", 4'd2, 1'b1, 16'h0000, 1'b0);
    tick();
    chk_out("bp_idle", 4'd2, 1'b0, 16'h0000, 1'b0);

    // overflow and clr
    do_reset();
    ready = 1'b0;
    req   = 16'h000A;
    tick();
    req = 16'h0000;
    tick();
    chk_out("ov_setup", 4'd1, 1'b1, 16'h0008, 1'b0);
    req = 16'h0002;
    tick();
    chk_out("ov_inflight", 4'd1, 1'b1, 16'h000A, 1'b0);
    req = 16'h0008;
    tick();
    chk_out("ov_set", 4'd1, 1'b1, 16'h000A, 1'b1);
    req = 16'h0000;
    tick();
    chk_out("ov_sticky", 4'd1, 1'b1, 16'h000A, 1'b1);
    clr   = 1'b1;
    ready = 1'b1;
    req   = 16'hFFFF;
    tick();
    chk_out("clr", 4'd1, 1'b0, 16'h0000, 1'b0);
    clr = 1'b0;
    req = 16'h0000;
    tick();
    chk_out("clr_after", 4'd1, 1'b0, 16'h0000, 1'b0);

    // fairness: req[0] held, req[7] pulsed once
    do_reset();
    ready = 1'b1;
    req   = 16'h0081;
    tick();
    chk_out("fair_p", 4'd0, 1'b0, 16'h0081, 1'b0);
    req = 16'h0001;
    tick();
    chk({"fair_g1", ".sel"}, {28'd0, sel}, 32'd0);
    chk({"fair_g1", ".enable"}, {31'd0, enable}, 32'd1);
    tick();
    chk({"fair_g2", ".sel"}, {28'd0, sel}, 32'd7);
    chk({"fair_g2", ".pending"}, {16'd0, pending}, 32'h0001);
    tick();
    chk({"fair_g3", ".sel"}, {28'd0, sel}, 32'd0);
    chk({"fair_g3", ".enable"}, {31'd0, enable}, 32'd1);

    // all-ones burst grants 0..15 back to back
    do_reset();
    ready = 1'b1;
    req   = 16'hFFFF;
    tick();
    chk_out("all_p", 4'd0, 1'b0, 16'hFFFF, 1'b0);
    req = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("all_sel", {28'd0, sel}, i);
      chk("all_en", {31'd0, enable}, 32'd1);
    end
    tick();
    chk_out("all_idle", 4'd15, 1'b0, 16'h0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_sel_encoder.md
# sram_sel_encoder

Request-to-select encoder and scheduler for the SRAM word-select path: the encode-side counterpart of the 4:16 row decoder. It collects up to 16 independent word-access requests, queues them in a pending vector, and issues one at a time as a registered 4-bit `sel` plus `enable`. These outputs connect directly to the decoder's `select`/`enable` inputs. Arbitration is round-robin, and a valid/ready handshake provides backpressure from the downstream SRAM controller.

## Interface
- No parameters. Width is fixed at 16 requests and a 4-bit select to mate with the 4:16 decoder.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req` in 16: request strobes; each high bit is OR-ed into pending on the edge.
- `clr` in 1: synchronous flush of pending, the in-flight grant and `overflow`.
- `ready` in 1: downstream accepts the current grant; a transfer occurs on an edge where `enable && ready`.
- `sel` out 4: index of the granted request (decoder `select`).
- `enable` out 1: grant valid (decoder `enable`).
- `pending` out 16: registered pending vector, excluding the in-flight grant.
- `overflow` out 1: sticky flag; a request was lost.

## Operation
- State elements: `pending[15:0]`, output register {`enable`, `sel`}, round-robin pointer `ptr[3:0]`, `overflow`.
- Two-state output FSM:
  - IDLE (`enable`=0) goes to GRANT when `pending` != 0.
  - GRANT (`enable`=1) stays in GRANT while `ready`=0; `sel` and `enable` are held stable.
  - On `ready`=1 in GRANT: reload from `pending` if it is nonzero (stay in GRANT), otherwise go to IDLE.
- `load` is true on an edge where (IDLE or (GRANT and `ready`)) and `pending` != 0.
- Selection on `load`:
  - Pick the first set bit of the registered `pending`, searching upward from `ptr` and wrapping 15→0.
  - `sel` gets that index and `enable` gets 1.
  - That bit is cleared from `pending`.
  - `ptr` gets index+1, mod 16 (15 wraps to 0).
- Pending update: `pending_next = (pending & ~load_mask) | req`.
  - A `req` bit arriving on the same edge that its index is loaded sets pending again. This is a new request, not an overflow.
- Overflow: set when `req[i]` && `pending[i]` for any i, using the registered pending value before the update. It stays sticky until `clr` or reset.
  - A `req` matching only the in-flight `sel` is not an overflow.
- `clr`=1:
  - `pending`, `overflow` and `enable` go to 0.
  - `req` on the same edge is ignored.
  - `ptr` and `sel` keep their values.
  - The `ready` handshake on that edge is discarded; no new load occurs.
- When `enable`=0, `sel` holds its last value. Downstream must qualify `sel` with `enable`.
- Priority order: `rst_n` > `clr` > normal operation.

## Timing
- Reset values, applied on an edge with `rst_n`=0:
  - `sel`=0, `enable`=0, `pending`=0, `overflow`=0, `ptr`=0.
  - `req` is ignored during reset.
- Latency: a `req` sampled at edge N appears in `pending` after N. The grant (`enable`=1, `sel`) appears after edge N+1, so there are 2 edges from a strobe to a visible grant.
- Throughput: one grant per cycle while `ready`=1 and `pending` is nonzero. There are no idle bubbles between back-to-back grants.
- Between transfers, `sel` and `enable` are stable; they change only on an accepting edge, `clr`, or reset.
- Reset or `clr` while in GRANT drops `enable` on that edge. The un-accepted grant is lost and is not re-queued.
- All-ones `req` from IDLE with `ptr`=0 and `ready` held 1 grants indices 0..15 in order over 16 consecutive cycles.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with `req`=16'hFFFF and `ready`=1 → `sel`=0, `enable`=0, `pending`=0, `overflow`=0 throughout; 2 edges after release, `enable` is still 0.
- **Single request:** from reset, pulse `req`=16'h0020 for 1 cycle with `ready`=1 → `pending`=16'h0020 after edge 1; `enable`=1, `sel`=5, `pending`=0 after edge 2; `enable`=0 after edge 3.
- **Wrap and round-robin:** from reset, pulse `req`=16'h8001 → grants `sel`=0 then `sel`=15 on consecutive cycles. Then pulse `req`=16'h0003 → `sel`=0 then 1, because the pointer wrapped to 0.
- **Backpressure:** pulse `req`=16'h0006 with `ready`=0 → `sel`=1 and `enable`=1 are held for 10 cycles with `pending`=16'h0004. Raise `ready` → `sel`=2 on the next edge, then `enable`=0.
- **Overflow and clr:** with `ready`=0, in-flight `sel`=1 and `pending`=16'h0008:
  - Pulse `req`=16'h0002 → `overflow` stays 0.
  - Pulse `req`=16'h0008 → `overflow`=1.
  - Assert `clr` together with `req`=16'hFFFF → `pending`=0, `enable`=0, `overflow`=0 on the next edge.
- **Fairness:** hold `req[0]`=1 every cycle, pulse `req[7]` once, `ready`=1 → index 7 is granted within 2 grants of entering `pending`, and grants alternate 0, 7, 0.
